// File: rtl/riscv_dmem_if.sv
// Data-port bundle between the core and the data-memory subsystem.
// The core drives requests as master; riscv_dmem answers as slave.
interface riscv_dmem_if;
  logic        W_en;
  logic        R_en;
  logic [31:0] ram_addr;
  logic [2:0]  RW_type;
  logic [31:0] Wr_mem_data;
  logic [31:0] Rd_mem_data;

  modport master (
    output W_en, R_en, ram_addr, RW_type, Wr_mem_data,
    input  Rd_mem_data
  );

  modport slave (
    input  W_en, R_en, ram_addr, RW_type, Wr_mem_data,
    output Rd_mem_data
  );
endinterface

// File: rtl/riscv_dmem.sv
// Data memory with byte-lane stores, extending loads and a small MMIO window
// (LED, free-running cycle counter, sticky access-error status/address).
module riscv_dmem #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic            clk,
  input  logic            rst_n,
  riscv_dmem_if.slave     bus,
  output logic [15:0]     led,
  output logic [1:0]      err_status,
  output logic [31:0]     err_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [15:0] led_q, led_d;
  logic [31:0] cycle_q, cycle_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] errAddr_q, errAddr_d;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  rwType;
  logic [AW-1:0] wordIdx;

  logic isRam, isMmio, isHalf, isWord;
  logic loadTypeOk, storeTypeOk, typeOk;
  logic alignBad, misaligned, access, mapOk;
  logic errMis, errMap, storeOk, loadOk, mmioWr;

  logic [31:0] ramWord, mmioWord, rawWord, rdData;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [3:0]  byteEn;
  logic [31:0] wdataRep;

  assign addr    = bus.ram_addr;
  assign wdata   = bus.Wr_mem_data;
  assign rwType  = bus.RW_type;
  assign wordIdx = addr[AW+1:2];

  assign isRam  = (addr[31:AW+2] == '0);
  assign isMmio = (addr[31:4] == MMIO_BASE[31:4]);
  assign isHalf = (rwType[1:0] == 2'b01);
  assign isWord = (rwType[1:0] == 2'b10);

  assign loadTypeOk  = rwType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign storeTypeOk = rwType inside {3'b000, 3'b001, 3'b010};
  // A combined load+store request is judged by the store's legality.
  assign typeOk      = bus.W_en ? storeTypeOk : loadTypeOk;

  assign alignBad   = (isHalf & addr[0]) | (isWord & (addr[1:0] != 2'b00));
  assign misaligned = typeOk & alignBad;
  assign access     = bus.W_en | bus.R_en;
  assign mapOk      = isRam | (isMmio & isWord);

  assign errMis  = access & misaligned;
  assign errMap  = access & ~misaligned & (~typeOk | ~mapOk);
  assign storeOk = bus.W_en & storeTypeOk & ~alignBad & mapOk;
  assign loadOk  = bus.R_en & loadTypeOk & ~alignBad & mapOk;
  assign mmioWr  = storeOk & ~isRam & isMmio;

  assign ramWord = mem[wordIdx];

  always_comb begin
    mmioWord = 32'h0;
    case (addr[3:2])
      2'd0:    mmioWord = {16'h0, led_q};
      2'd1:    mmioWord = cycle_q;
      2'd2:    mmioWord = {30'h0, err_q};
      default: mmioWord = errAddr_q;
    endcase
  end

  always_comb begin
    rawWord = isRam ? ramWord : mmioWord;
    byteSel = 8'h0;
    case (addr[1:0])
      2'd0:    byteSel = rawWord[7:0];
      2'd1:    byteSel = rawWord[15:8];
      2'd2:    byteSel = rawWord[23:16];
      default: byteSel = rawWord[31:24];
    endcase
    halfSel = addr[1] ? rawWord[31:16] : rawWord[15:0];
    rdData  = 32'h0;
    if (loadOk) begin
      // RW_type[2] selects zero extension for lbu/lhu.
      case (rwType[1:0])
        2'b00:   rdData = {{24{byteSel[7] & ~rwType[2]}}, byteSel};
        2'b01:   rdData = {{16{halfSel[15] & ~rwType[2]}}, halfSel};
        default: rdData = rawWord;
      endcase
    end
  end

  assign bus.Rd_mem_data = rdData;

  always_comb begin
    byteEn   = 4'b0000;
    wdataRep = wdata;
    case (rwType[1:0])
      2'b00: begin
        byteEn   = 4'b0001 << addr[1:0];
        wdataRep = {4{wdata[7:0]}};
      end
      2'b01: begin
        byteEn   = addr[1] ? 4'b1100 : 4'b0011;
        wdataRep = {2{wdata[15:0]}};
      end
      default: byteEn = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && storeOk && isRam) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wdataRep[8*b +: 8];
      end
    end
  end

  always_comb begin
    led_d     = led_q;
    cycle_d   = cycle_q + 32'd1;
    err_d     = err_q;
    errAddr_d = errAddr_q;
    if (mmioWr) begin
      case (addr[3:2])
        2'd0:    led_d   = wdata[15:0];
        2'd1:    cycle_d = wdata;
        2'd2:    err_d   = err_q & ~wdata[1:0];
        default: ;
      endcase
    end
    if (errMis) err_d[0] = 1'b1;
    if (errMap) err_d[1] = 1'b1;
    // Only the first fault since the status was last all-clear is recorded.
    if ((err_q == 2'b00) && (errMis || errMap)) errAddr_d = addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q     <= 16'h0;
      cycle_q   <= 32'h0;
      err_q     <= 2'b00;
      errAddr_q <= 32'h0;
    end else begin
      led_q     <= led_d;
      cycle_q   <= cycle_d;
      err_q     <= err_d;
      errAddr_q <= errAddr_d;
    end
  end

  assign led        = led_q;
  assign err_status = err_q;
  assign err_addr   = errAddr_q;

endmodule

// File: tb/tb_riscv_dmem.sv
// Scoreboard bench for riscv_dmem: expected load data is queued when a
// request is driven and compared when the combinational result settles.
module tb_riscv_dmem;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] MMIO  = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] led;
  logic [1:0]  err_status;
  logic [31:0] err_addr;

  riscv_dmem_if bus();

  riscv_dmem #(.DEPTH(DEPTH), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .led(led), .err_status(err_status), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] expQ[$];
  string       tagQ[$];

  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a,
                               input logic [2:0] t, input logic [31:0] d);
    bus.W_en = w; bus.R_en = r; bus.ram_addr = a; bus.RW_type = t; bus.Wr_mem_data = d;
  endtask

  task automatic pushExp(input string tag, input logic [31:0] v);
    tagQ.push_back(tag);
    expQ.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 32'h0, 3'b000, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    vectors++;
    if (led !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_led: got %h expected 0000", led); end
    vectors++;
    if (err_status !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 00", err_status); end
    vectors++;
    if (err_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_erraddr: got %h expected 0", err_addr); end
  endtask

  task automatic test_load_ext();
    logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [2:0]  types [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps  [4] = '{32'hFFFF_FF87, 32'h0000_0087, 32'hFFFF_8765, 32'h0000_4321};
    logic [31:0] exp;
    string tag;
    applyStimulus(1, 0, 32'h10, 3'b010, 32'h8765_4321);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, addrs[i], types[i], 32'h0);
      pushExp($sformatf("load_ext%0d", i), exps[i]);
      @(negedge clk);
      exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
      if (bus.Rd_mem_data !== exp) begin
        miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
      end
      tick();
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] exp;
    string tag;
    applyStimulus(1, 0, 32'h0, 3'b010, 32'hAABB_CCDD); tick();
    applyStimulus(1, 0, 32'h1, 3'b000, 32'hFFFF_FF11); tick();
    applyStimulus(1, 0, 32'h2, 3'b001, 32'hFFFF_2233); tick();
    applyStimulus(0, 1, 32'h0, 3'b010, 32'h0);
    pushExp("lanes_word0", 32'h2233_11DD);
    @(negedge clk);
    exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
    if (bus.Rd_mem_data !== exp) begin
      miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
    end
    tick();
  endtask

  task automatic test_misaligned();
    logic [31:0] exp;
    string tag;
    applyStimulus(0, 1, 32'h6, 3'b010, 32'h0);
    pushExp("mis_lw_data", 32'h0);
    @(negedge clk);
    exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
    if (bus.Rd_mem_data !== exp) begin
      miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
    end
    tick();
    applyStimulus(1, 0, 32'h3, 3'b001, 32'h0000_BEEF);
    tick();
    vectors++;
    if (err_status !== 2'b01) begin miscompares++; $display("[TB] FAIL mis_status: got %b expected 01", err_status); end
    vectors++;
    if (err_addr !== 32'h6) begin miscompares++; $display("[TB] FAIL mis_addr: got %h expected 00000006", err_addr); end
    applyStimulus(0, 1, 32'h0, 3'b010, 32'h0);
    pushExp("mis_ram_intact", 32'h2233_11DD);
    @(negedge clk);
    exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
    if (bus.Rd_mem_data !== exp) begin
      miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
    end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5] = '{DEPTH*4, 32'h44, MMIO + 32'h8, MMIO + 32'hC, MMIO};
    logic [2:0]  types [5] = '{3'b010, 3'b011, 3'b010, 3'b010, 3'b000};
    logic [31:0] exps  [5] = '{32'h0, 32'h0, 32'h2, DEPTH*4, 32'h0};
    logic [31:0] exp;
    string tag;
    applyStimulus(1, 0, MMIO + 32'h8, 3'b010, 32'h1);
    tick();
    vectors++;
    if (err_status !== 2'b00) begin miscompares++; $display("[TB] FAIL clear_status: got %b expected 00", err_status); end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, addrs[i], types[i], 32'h0);
      pushExp($sformatf("err_load%0d", i), exps[i]);
      @(negedge clk);
      exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
      if (bus.Rd_mem_data !== exp) begin
        miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
      end
      tick();
      vectors++;
      if (err_status !== 2'b10) begin miscompares++; $display("[TB] FAIL err_status%0d: got %b expected 10", i, err_status); end
      vectors++;
      if (err_addr !== DEPTH*4) begin miscompares++; $display("[TB] FAIL err_addr%0d: got %h expected %h", i, err_addr, DEPTH*4); end
    end
    applyStimulus(1, 0, MMIO + 32'h8, 3'b010, 32'h3);
    tick();
    applyStimulus(0, 1, 32'h21, 3'b001, 32'h0);
    tick();
    vectors++;
    if (err_status !== 2'b01) begin miscompares++; $display("[TB] FAIL recap_status: got %b expected 01", err_status); end
    vectors++;
    if (err_addr !== 32'h21) begin miscompares++; $display("[TB] FAIL recap_addr: got %h expected 00000021", err_addr); end
  endtask

  task automatic test_counter_led();
    logic [31:0] exps [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] exp;
    string tag;
    applyStimulus(1, 0, MMIO + 32'h4, 3'b010, 32'hFFFF_FFFE);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, MMIO + 32'h4, 3'b010, 32'h0);
      pushExp($sformatf("cycle%0d", i), exps[i]);
      @(negedge clk);
      exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
      if (bus.Rd_mem_data !== exp) begin
        miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
      end
      tick();
    end
    applyStimulus(1, 0, MMIO, 3'b010, 32'h1234_ABCD);
    tick();
    vectors++;
    if (led !== 16'hABCD) begin miscompares++; $display("[TB] FAIL led_out: got %h expected abcd", led); end
    applyStimulus(0, 1, MMIO, 3'b010, 32'h0);
    pushExp("led_read", 32'h0000_ABCD);
    @(negedge clk);
    exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
    if (bus.Rd_mem_data !== exp) begin
      miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exps [2] = '{32'h0000_0044, 32'h0000_0055};
    logic [31:0] exp;
    string tag;
    applyStimulus(1, 0, 32'h30, 3'b010, 32'h44);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(i == 0, 1, 32'h30, 3'b010, 32'h55);
      pushExp($sformatf("rbw%0d", i), exps[i]);
      @(negedge clk);
      exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
      if (bus.Rd_mem_data !== exp) begin
        miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
      end
      tick();
    end
    vectors++;
    if (err_status !== 2'b01) begin miscompares++; $display("[TB] FAIL rbw_status: got %b expected 01", err_status); end
  endtask

  task automatic test_reset_store();
    logic [31:0] exps [3] = '{32'h0, 32'h1, 32'h1111_1111};
    logic [31:0] addrs [3] = '{MMIO + 32'h4, MMIO + 32'h4, 32'h20};
    logic [31:0] exp;
    string tag;
    applyStimulus(1, 0, 32'h20, 3'b010, 32'h1111_1111);
    tick();
    rst_n = 1'b0;
    applyStimulus(1, 0, 32'h20, 3'b010, 32'h5);
    tick();
    rst_n = 1'b1;
    vectors++;
    if (led !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_led: got %h expected 0000", led); end
    vectors++;
    if (err_status !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_err: got %b expected 00", err_status); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, addrs[i], 3'b010, 32'h0);
      pushExp($sformatf("rst_read%0d", i), exps[i]);
      @(negedge clk);
      exp = expQ.pop_front(); tag = tagQ.pop_front(); vectors++;
      if (bus.Rd_mem_data !== exp) begin
        miscompares++; $display("[TB] FAIL %s: got %h expected %h", tag, bus.Rd_mem_data, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_byte_lanes();
    test_misaligned();
    test_errors();
    test_counter_led();
    test_back_to_back();
    test_reset_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/riscv_dmem.md
Name: riscv_dmem

Overview:
- Data-memory subsystem sitting directly downstream of the single-cycle core's data port; consumes W_en, R_en, ram_addr, RW_type and Wr_mem_data, and returns Rd_mem_data.
- Contains a word-organised RAM with byte-lane stores and sign/zero-extending loads.
- Also contains a small MMIO window: LED register, free-running cycle counter, and a sticky access-error status with captured fault address.
- Read path is combinational so the core completes loads in one cycle; all state updates occur on the rising clock edge.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words. Power of two; RAM occupies byte addresses 0 .. DEPTH*4-1.
- MMIO_BASE, 32'hFFFF_FF00, base byte address of the MMIO window (16 bytes).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- W_en  in  1  store request this cycle
- R_en  in  1  load request this cycle
- ram_addr  in  32  byte address (ALU result)
- RW_type  in  3  access type, equal to instruction func3
- Wr_mem_data  in  32  store data (rs2), low-aligned
- Rd_mem_data  out  32  load result, already extended
- led  out  16  LED register contents
- err_status  out  2  sticky errors: bit0 misaligned, bit1 unmapped/illegal type
- err_addr  out  32  address of first error since last clear

Behaviour:
- Reset (rst_n=0 at posedge):
  - led=0, cycle counter=0, err_status=0, err_addr=0.
  - RAM contents are not reset.
  - W_en is ignored during reset.
  - Rd_mem_data stays combinational and follows current inputs.
- Decode:
  - RAM if ram_addr < DEPTH*4; word index = ram_addr[log2(DEPTH)+1:2].
  - MMIO if ram_addr[31:4] == MMIO_BASE[31:4]:
    - offset 0x0: LED, bits [15:0] R/W, upper bits read 0.
    - offset 0x4: CYCLE, R/W.
    - offset 0x8: STATUS, read {30'b0, err_status}; write-1-to-clear per bit.
    - offset 0xC: ERRADDR, read-only.
  - Anything else is unmapped.
- RW_type:
  - 000 byte signed (loads) / sb.
  - 001 half signed / sh.
  - 010 word / sw.
  - 100 byte unsigned (loads).
  - 101 half unsigned (loads).
  - 011, 110, 111 are illegal. 100 and 101 are also illegal for stores.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- Loads (R_en=1, W_en=0), combinational:
  - Select byte/half lane by addr[1:0]; extend to 32 bits (sign for 000/001, zero for 100/101).
  - MMIO: only word accesses are legal.
  - Misaligned, unmapped, or illegal access: Rd_mem_data=0.
  - R_en=0: Rd_mem_data=0.
- Stores (W_en=1), at posedge:
  - sb writes lane addr[1:0] with Wr_mem_data[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with Wr_mem_data[15:0].
  - sw writes all 4 lanes.
  - Other lanes of the word are unchanged.
  - An erroneous store writes nothing.
- Both W_en and R_en high: the store executes; Rd_mem_data shows pre-edge contents (read-before-write). This is not an error.
- Cycle counter:
  - Increments by 1 every non-reset cycle; wraps 0xFFFF_FFFF -> 0.
  - A legal sw to CYCLE loads Wr_mem_data instead of incrementing that cycle.
  - A load of CYCLE returns the pre-edge value.
- Errors, evaluated only when W_en or R_en is high:
  - Misaligned access sets err_status[0].
  - Unmapped address, illegal RW_type, or non-word MMIO access sets err_status[1].
  - Misalignment is checked first: a misaligned access sets only bit0.
  - err_addr captures ram_addr only when err_status==0 before the edge (first fault).
  - Status is sticky until cleared.
  - A STATUS write clears the bits set in Wr_mem_data[1:0]; a new error in the same cycle is the store itself, so it is never a legal clear. Clear and new error cannot coincide.
  - After a clear to 0, the next error recaptures err_addr.
- Latency:
  - Load data: 0 cycles (combinational).
  - Stores, LED, STATUS, counter updates: visible the cycle after the edge.

Test Plan:
- sw 0x8765_4321 @0x10; then lb @0x13, lbu @0x13, lh @0x12, lhu @0x10 -> 0xFFFF_FF87, 0x0000_0087, 0xFFFF_8765, 0x0000_4321.
- After word 0x0 = 0xAABB_CCDD: sb 0x11 @0x1, then sh 0x2233 @0x2 -> lw @0x0 = 0x2233_11DD.
- lw @0x6 then sh @0x3 -> Rd_mem_data=0, RAM unchanged, err_status=01, err_addr=0x6 (not 0x3).
- sw 0x1 to 0xFFFF_FF08 -> err_status=00. Then lw @DEPTH*4 -> err_status=10, err_addr=DEPTH*4. Then RW_type=011 load -> err_addr unchanged.
- sw 0xFFFF_FFFE to CYCLE; read 0xFFFF_FF04 on the next two cycles -> 0xFFFF_FFFE, then 0xFFFF_FFFF, and the third cycle reads 0x0. sw 0x1234_ABCD to LED -> led=0xABCD, lw LED = 0x0000_ABCD.
- Assert rst_n=0 for one cycle while W_en=1 (sw 0x5 @0x20) -> word 0x20 is not written; led, counter and err_status are 0 next cycle; counter reads 1 one cycle later.
